// File: rtl/pipeline_hazard_unit.sv
// Decode-side hazard unit: raises want_stall on load-use / dmem wait, sequences
// taken jumps through RESOLVE and RELEASE, and keeps saturating perf counters.
module pipeline_hazard_unit #(
  parameter int COUNTER_WIDTH = 32
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     jump_start,
  input  logic [4:0]               decode_rs1,
  input  logic [4:0]               decode_rs2,
  input  logic                     decode_uses_rs1,
  input  logic                     decode_uses_rs2,
  input  logic                     ex_valid,
  input  logic                     ex_mem_read,
  input  logic [4:0]               ex_rd,
  input  logic                     data_mem_wait,
  input  logic                     counter_clear,
  output logic [1:0]               branch_status,
  output logic                     want_stall,
  output logic                     fetch_flush,
  output logic [COUNTER_WIDTH-1:0] stall_cycle_count,
  output logic [COUNTER_WIDTH-1:0] jump_count
);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    RESOLVE = 2'b01,
    RELEASE = 2'b10,
    ILLEGAL = 2'b11
  } state_t;

  state_t                   r_state;
  logic                     r_flush;
  logic [COUNTER_WIDTH-1:0] r_stall_cnt;
  logic [COUNTER_WIDTH-1:0] r_jump_cnt;
  logic                     w_rs1_hit;
  logic                     w_rs2_hit;
  logic                     w_load_use;
  logic                     w_freeze;
  logic                     w_jump_acc;

  assign w_rs1_hit  = decode_uses_rs1 && (decode_rs1 == ex_rd);
  assign w_rs2_hit  = decode_uses_rs2 && (decode_rs2 == ex_rd);
  assign w_load_use = ex_valid && ex_mem_read && (ex_rd != 5'd0) && (w_rs1_hit || w_rs2_hit);
  assign w_freeze   = w_load_use || data_mem_wait;
  assign w_jump_acc = (r_state == IDLE) && jump_start && !w_freeze;

  // fetch_flush is registered alongside the state so it tracks RESOLVE exactly,
  // including frozen cycles where the state is held.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_flush <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_jump_acc) begin
            r_state <= RESOLVE;
            r_flush <= 1'b1;
          end
        end
        RESOLVE: begin
          if (!w_freeze) begin
            r_state <= RELEASE;
            r_flush <= 1'b0;
          end
        end
        RELEASE: begin
          if (!w_freeze) r_state <= IDLE;
          r_flush <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          r_flush <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_stall_cnt <= '0;
      r_jump_cnt  <= '0;
    end else begin
      if (counter_clear)                    r_stall_cnt <= '0;
      else if (w_freeze && ~&r_stall_cnt)   r_stall_cnt <= r_stall_cnt + 1'b1;
      if (counter_clear)                    r_jump_cnt  <= '0;
      else if (w_jump_acc && ~&r_jump_cnt)  r_jump_cnt  <= r_jump_cnt + 1'b1;
    end
  end

  assign branch_status     = r_state;
  assign fetch_flush       = r_flush;
  assign want_stall        = w_freeze;
  assign stall_cycle_count = r_stall_cnt;
  assign jump_count        = r_jump_cnt;

endmodule

// File: tb/tb_pipeline_hazard_unit.sv
// Directed stimulus with a scoreboard queue; a negedge monitor pops and checks.
module tb_pipeline_hazard_unit;

  localparam int CW = 4;

  logic          clock = 1'b0;
  logic          reset;
  logic          jump_start;
  logic [4:0]    decode_rs1, decode_rs2, ex_rd;
  logic          decode_uses_rs1, decode_uses_rs2;
  logic          ex_valid, ex_mem_read, data_mem_wait, counter_clear;
  logic [1:0]    branch_status;
  logic          want_stall, fetch_flush;
  logic [CW-1:0] stall_cycle_count, jump_count;

  pipeline_hazard_unit #(.COUNTER_WIDTH(CW)) dut (
    .clock(clock), .reset(reset), .jump_start(jump_start),
    .decode_rs1(decode_rs1), .decode_rs2(decode_rs2),
    .decode_uses_rs1(decode_uses_rs1), .decode_uses_rs2(decode_uses_rs2),
    .ex_valid(ex_valid), .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
    .data_mem_wait(data_mem_wait), .counter_clear(counter_clear),
    .branch_status(branch_status), .want_stall(want_stall), .fetch_flush(fetch_flush),
    .stall_cycle_count(stall_cycle_count), .jump_count(jump_count)
  );

  always #5 clock = ~clock;

  // mask bits: [0] status [1] flush [2] want_stall [3] stall count [4] jump count
  typedef struct {
    string         name;
    logic [4:0]    m;
    logic [1:0]    st;
    logic          fl;
    logic          ws;
    logic [CW-1:0] sc;
    logic [CW-1:0] jc;
  } exp_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  function automatic void expect_out(string n, logic [4:0] m, logic [1:0] st, logic fl,
                                     logic ws, logic [CW-1:0] sc, logic [CW-1:0] jc);
    exp_t e;
    e.name = n; e.m = m; e.st = st; e.fl = fl; e.ws = ws; e.sc = sc; e.jc = jc;
    q.push_back(e);
  endfunction

  always @(negedge clock) begin
    while (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      if (e.m[0]) begin
        n_chk++;
        if (branch_status !== e.st) begin
          n_fail++;
          $display("FAIL %s status got %b want %b", e.name, branch_status, e.st);
        end
      end
      if (e.m[1]) begin
        n_chk++;
        if (fetch_flush !== e.fl) begin
          n_fail++;
          $display("FAIL %s fetch_flush got %b want %b", e.name, fetch_flush, e.fl);
        end
      end
      if (e.m[2]) begin
        n_chk++;
        if (want_stall !== e.ws) begin
          n_fail++;
          $display("FAIL %s want_stall got %b want %b", e.name, want_stall, e.ws);
        end
      end
      if (e.m[3]) begin
        n_chk++;
        if (stall_cycle_count !== e.sc) begin
          n_fail++;
          $display("FAIL %s stall_cycle_count got %0d want %0d", e.name, stall_cycle_count, e.sc);
        end
      end
      if (e.m[4]) begin
        n_chk++;
        if (jump_count !== e.jc) begin
          n_fail++;
          $display("FAIL %s jump_count got %0d want %0d", e.name, jump_count, e.jc);
        end
      end
    end
  end

  // jump_start is only legal while the sequencer is idle
  always @(posedge clock) begin
    if (!reset && jump_start && branch_status != 2'b00) begin
      n_fail++;
      $display("FAIL protocol jump_start in status %b", branch_status);
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset = 1'b1; jump_start = 0; decode_rs1 = 0; decode_rs2 = 0; ex_rd = 0;
    decode_uses_rs1 = 0; decode_uses_rs2 = 0; ex_valid = 0; ex_mem_read = 0;
    data_mem_wait = 0; counter_clear = 0;

    step(); expect_out("reset_a", 5'b11111, 2'b00, 0, 0, 0, 0);
    step(); expect_out("reset_b", 5'b11111, 2'b00, 0, 0, 0, 0);
    reset = 0;

    // single jump
    step(); step(); jump_start = 1; expect_out("j_idle", 5'b10011, 2'b00, 0, 0, 0, 0);
    step(); jump_start = 0;         expect_out("j_res",  5'b10011, 2'b01, 1, 0, 0, 1);
    step();                         expect_out("j_rel",  5'b00011, 2'b10, 0, 0, 0, 0);
    step();                         expect_out("j_done", 5'b10011, 2'b00, 0, 0, 0, 1);

    // load-use detection
    step(); ex_valid = 1; ex_mem_read = 1; ex_rd = 5; decode_rs1 = 5; decode_uses_rs1 = 1;
    expect_out("lu_rs1", 5'b00100, 0, 0, 1, 0, 0);
    step(); ex_rd = 0;        expect_out("lu_x0",   5'b00100, 0, 0, 0, 0, 0);
    step(); ex_rd = 5; decode_uses_rs1 = 0;
    expect_out("lu_nouse", 5'b00100, 0, 0, 0, 0, 0);
    step(); decode_rs2 = 5; decode_uses_rs2 = 1;
    expect_out("lu_rs2", 5'b00100, 0, 0, 1, 0, 0);
    step(); ex_mem_read = 0;  expect_out("lu_noload", 5'b00100, 0, 0, 0, 0, 0);
    step(); ex_mem_read = 1; ex_valid = 0;
    expect_out("lu_bubble", 5'b00100, 0, 0, 0, 0, 0);
    ex_mem_read = 0; decode_uses_rs2 = 0; ex_rd = 0; decode_rs1 = 0; decode_rs2 = 0;

    step(); counter_clear = 1;
    step(); counter_clear = 0; expect_out("clear", 5'b11000, 0, 0, 0, 0, 0);

    // freeze during RESOLVE
    jump_start = 1; expect_out("f_idle", 5'b00111, 2'b00, 0, 0, 0, 0);
    step(); jump_start = 0; data_mem_wait = 1;
    expect_out("f_res0", 5'b11111, 2'b01, 1, 1, 0, 1);
    step(); expect_out("f_res1", 5'b01111, 2'b01, 1, 1, 1, 0);
    step(); expect_out("f_res2", 5'b01111, 2'b01, 1, 1, 2, 0);
    step(); data_mem_wait = 0;
    expect_out("f_res3", 5'b01111, 2'b01, 1, 0, 3, 0);
    step(); expect_out("f_rel",  5'b01111, 2'b10, 0, 0, 3, 0);
    step(); expect_out("f_done", 5'b11111, 2'b00, 0, 0, 3, 1);

    // reset mid-sequence, then a full sequence and a back-to-back jump
    jump_start = 1;
    step(); jump_start = 0;
    step(); reset = 1; expect_out("mr_async", 5'b11011, 2'b00, 0, 0, 0, 0);
    step(); expect_out("mr_hold", 5'b11011, 2'b00, 0, 0, 0, 0);
    reset = 0; jump_start = 1;
    step(); jump_start = 0; expect_out("mr_res",  5'b10011, 2'b01, 1, 0, 0, 1);
    step();                 expect_out("mr_rel",  5'b00011, 2'b10, 0, 0, 0, 0);
    step(); jump_start = 1; expect_out("b2b_idle", 5'b10011, 2'b00, 0, 0, 0, 1);
    step(); jump_start = 0; expect_out("b2b_res", 5'b10011, 2'b01, 1, 0, 0, 2);
    step();                 expect_out("b2b_rel", 5'b00011, 2'b10, 0, 0, 0, 0);
    step();                 expect_out("b2b_done", 5'b10011, 2'b00, 0, 0, 0, 2);

    // saturation and clear-over-increment
    counter_clear = 1;
    step(); counter_clear = 0; data_mem_wait = 1;
    expect_out("sat_start", 5'b01000, 0, 0, 0, 0, 0);
    repeat (20) step();
    counter_clear = 1; expect_out("sat_full", 5'b01101, 2'b00, 0, 1, 15, 0);
    step(); counter_clear = 0; expect_out("sat_clr", 5'b01000, 0, 0, 0, 0, 0);
    step(); data_mem_wait = 0; expect_out("sat_inc", 5'b01100, 0, 0, 0, 1, 0);

    step(); step();
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain queue left %0d want 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_unit.md
# pipeline_hazard_unit

Responder side of the pipeline controller's jump/stall handshake. Generates `want_stall` from load-use and data-memory-wait hazards, and sequences every taken control transfer: it accepts `jump_start` and walks `branch_status` through resolve and release phases. Sits beside the pipeline controller in decode and feeds it directly. Also keeps saturating performance counters for stall cycles and jumps.

## Interface
- Parameters
- COUNTER_WIDTH, 32: width of both performance counters.
- Ports
- clock  in  1  core clock, single domain.
- reset  in  1  asynchronous, active-high reset.
- jump_start  in  1  from controller; a jump/branch in decode requests sequencing.
- decode_rs1, decode_rs2  in  5 each  source registers of the decode-stage instruction.
- decode_uses_rs1, decode_uses_rs2  in  1 each  the source is actually read.
- ex_valid  in  1  execute stage holds a real instruction (not a bubble).
- ex_mem_read  in  1  execute-stage instruction is a load.
- ex_rd  in  5  destination of the execute-stage instruction.
- data_mem_wait  in  1  data memory not ready this cycle.
- counter_clear  in  1  synchronous clear of both counters.
- branch_status  out  2  sequencer phase, to controller.
- want_stall  out  1  hazard stall request, to controller.
- fetch_flush  out  1  squash the instruction currently in fetch (wrong path).
- stall_cycle_count  out  COUNTER_WIDTH  cycles with want_stall high.
- jump_count  out  COUNTER_WIDTH  accepted jump_start events.

## Operation
- Sequencer states, encoded directly as branch_status:
- IDLE 2'b00: controller holds PC, stalls decode, asserts jump_start and writes the link register.
- RESOLVE 2'b01: controller loads the target PC; decode stays stalled; fetch_flush = 1.
- RELEASE 2'b10: controller writes PC+4 and releases decode (no_stall = 1).
- 2'b11 is never produced; if entered, it returns to IDLE next cycle.
- Transitions are gated by freeze = want_stall:
- IDLE -> RESOLVE when jump_start && !freeze; RESOLVE -> RELEASE when !freeze; RELEASE -> IDLE when !freeze. The state is held otherwise.
- jump_start outside IDLE is a protocol error; it is ignored, and the bench flags it.
- Hazard detection (combinational):
- load_use = ex_valid & ex_mem_read & (ex_rd != 0) & ((decode_uses_rs1 & decode_rs1 == ex_rd) | (decode_uses_rs2 & decode_rs2 == ex_rd)).
- want_stall = load_use | data_mem_wait.
- fetch_flush = (branch_status == 2'b01), and is independent of freeze.
- Counters:
- stall_cycle_count increments each cycle want_stall = 1.
- jump_count increments on each accepted IDLE->RESOLVE transition.
- Both counters saturate at all-ones.
- counter_clear has priority over increment; the counter reads 0 the next cycle.

## Timing
- Reset values: branch_status 2'b00, fetch_flush 0, both counters 0.
- want_stall follows its inputs combinationally and is 0 whenever its inputs are inactive.
- Reset takes effect immediately, including mid-sequence: status returns to 00 without waiting for a clock edge.
- Nominal jump, jump_start high at edge N: status 01 in cycle N+1, 10 in N+2, 00 in N+3. Total sequence latency is 3 cycles.
- A new jump_start in cycle N+3 is accepted, so back-to-back jumps cost 3 cycles each.
- Each frozen cycle extends the current phase by exactly one cycle. No phase is skipped or repeated beyond the freeze.
- The load-use stall lasts exactly 1 cycle once the controller injects a bubble, because ex_valid drops.
- Simultaneous events:
- counter_clear together with an increment gives 0.
- jump_start together with data_mem_wait cannot be accepted, because the controller suppresses jump_start under want_stall.
- All state updates occur on the rising clock edge.

## Test plan
- Reset: assert reset for 2 cycles at random state -> branch_status 00, fetch_flush 0, both counters 0, immediately on assertion.
- Single jump: jump_start pulse at cycle 5 -> status 01 with fetch_flush 1 in cycle 6, 10 in cycle 7, 00 in cycle 8; jump_count = 1.
- Load-use: ex_valid=1, ex_mem_read=1, ex_rd=5, decode_rs1=5, uses_rs1=1 -> want_stall 1. Setting ex_rd=0 -> 0; setting uses_rs1=0 -> 0; a rs2 match with uses_rs2=1 -> 1.
- Freeze: data_mem_wait high for 3 cycles while status = 01 -> status held at 01 for 4 cycles in total, then 10, then 00; stall_cycle_count = 3.
- Mid-sequence reset: assert reset while status = 10 -> status 00 before the next edge; after release, a jump_start gives a full 3-cycle sequence.
- Saturation with COUNTER_WIDTH = 4: 20 stall cycles -> stall_cycle_count = 15. Then counter_clear together with a stall -> 0 next cycle, 1 the cycle after.
